// File: rtl/exc_pipe_ctrl_if.sv
// Pipeline-side bundle for the exception/hazard sequencer: WB-stage status in,
// flush/stall/redirect controls and trap CSR values out.
interface exc_pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             wb_invalid;
  logic             wb_mis_ld;
  logic             wb_mis_st;
  logic             wb_mret;
  logic [31:0]      wb_pc_plus4;
  logic [31:0]      wb_idata;
  logic [31:0]      wb_daddr;
  logic             hz_stall;

  logic             wb_kill;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             flush_ex_mem;
  logic             flush_mem_wb;
  logic             stall_pc;
  logic             stall_if_id;
  logic             pc_redirect;
  logic [31:0]      pc_target;
  logic [31:0]      epc;
  logic [3:0]       cause;
  logic [31:0]      tval;
  logic             in_handler;
  logic             lockup;
  logic [CNT_W-1:0] exc_count;

  modport master (
    output wb_invalid, wb_mis_ld, wb_mis_st, wb_mret,
           wb_pc_plus4, wb_idata, wb_daddr, hz_stall,
    input  wb_kill, flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
           stall_pc, stall_if_id, pc_redirect, pc_target,
           epc, cause, tval, in_handler, lockup, exc_count
  );

  modport slave (
    input  wb_invalid, wb_mis_ld, wb_mis_st, wb_mret,
           wb_pc_plus4, wb_idata, wb_daddr, hz_stall,
    output wb_kill, flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
           stall_pc, stall_if_id, pc_redirect, pc_target,
           epc, cause, tval, in_handler, lockup, exc_count
  );
endinterface

// File: rtl/exc_pipe_ctrl.sv
// Exception/hazard sequencer: traps on WB-stage faults, returns on MRET, locks up on
// nested faults, and converts load-use hazards into stalls. EXC_PIPE_CTRL_COUNT_EN adds exc_count.
module exc_pipe_ctrl #(
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
  parameter int          CNT_W    = 16
) (
  input logic           clk,
  input logic           rst,
  exc_pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HANDLER = 2'd1,
    ST_LOCKUP  = 2'd2
  } state_t;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_MIS_LD  = 4'd4;
  localparam logic [3:0] CAUSE_MIS_ST  = 4'd6;

  state_t      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [3:0]  cause_q, cause_d;
  logic [31:0] tval_q, tval_d;

  logic        any_fault;
  logic        kill, fl_if_id, fl_id_ex, fl_ex_mem, fl_mem_wb;
  logic        st_pc, st_if_id, redirect;
  logic [31:0] target;

  assign any_fault = bus.wb_invalid | bus.wb_mis_ld | bus.wb_mis_st;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned,
  // which is what keeps this block from inferring latches.
  always_comb begin
    state_d   = state_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    tval_d    = tval_q;
    kill      = 1'b0;
    fl_if_id  = 1'b0;
    fl_id_ex  = 1'b0;
    fl_ex_mem = 1'b0;
    fl_mem_wb = 1'b0;
    st_pc     = 1'b0;
    st_if_id  = 1'b0;
    redirect  = 1'b0;
    target    = 32'd0;

    unique case (state_q)
      ST_IDLE: begin
        if (any_fault || bus.wb_mret) begin
          kill      = 1'b1;
          {fl_if_id, fl_id_ex, fl_ex_mem, fl_mem_wb} = 4'b1111;
          redirect  = 1'b1;
          target    = TRAP_VEC;
          epc_d     = bus.wb_pc_plus4 - 32'd4;
          state_d   = ST_HANDLER;
          // A stray MRET outside the handler is reported as an illegal instruction.
          if (bus.wb_invalid || !any_fault) begin
            cause_d = CAUSE_ILLEGAL;
            tval_d  = bus.wb_idata;
          end else if (bus.wb_mis_ld) begin
            cause_d = CAUSE_MIS_LD;
            tval_d  = bus.wb_daddr;
          end else begin
            cause_d = CAUSE_MIS_ST;
            tval_d  = bus.wb_daddr;
          end
        end else if (bus.hz_stall) begin
          st_pc    = 1'b1;
          st_if_id = 1'b1;
          fl_id_ex = 1'b1;
        end
      end
      ST_HANDLER: begin
        if (any_fault) begin
          kill    = 1'b1;
          {fl_if_id, fl_id_ex, fl_ex_mem, fl_mem_wb} = 4'b1111;
          state_d = ST_LOCKUP;
        end else if (bus.wb_mret) begin
          {fl_if_id, fl_id_ex, fl_ex_mem, fl_mem_wb} = 4'b1111;
          redirect = 1'b1;
          target   = epc_q + 32'd4;
          state_d  = ST_IDLE;
        end else if (bus.hz_stall) begin
          st_pc    = 1'b1;
          st_if_id = 1'b1;
          fl_id_ex = 1'b1;
        end
      end
      ST_LOCKUP: begin
        st_pc    = 1'b1;
        fl_if_id = 1'b1;
        fl_id_ex = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Controls must stay quiet while reset is held, even with an event sitting in WB.
    if (rst) begin
      kill      = 1'b0;
      fl_if_id  = 1'b0;
      fl_id_ex  = 1'b0;
      fl_ex_mem = 1'b0;
      fl_mem_wb = 1'b0;
      st_pc     = 1'b0;
      st_if_id  = 1'b0;
      redirect  = 1'b0;
      target    = 32'd0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; the async reset clears the CSR values as well as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      epc_q   <= 32'd0;
      cause_q <= 4'd0;
      tval_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      tval_q  <= tval_d;
    end
  end

`ifdef EXC_PIPE_CTRL_COUNT_EN
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_inc = ((state_q == ST_IDLE) && (any_fault || bus.wb_mret)) ||
                   ((state_q == ST_HANDLER) && any_fault);
  assign cnt_d   = (cnt_inc && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.exc_count = cnt_q;
`else
  assign bus.exc_count = '0;
`endif

  assign bus.wb_kill      = kill;
  assign bus.flush_if_id  = fl_if_id;
  assign bus.flush_id_ex  = fl_id_ex;
  assign bus.flush_ex_mem = fl_ex_mem;
  assign bus.flush_mem_wb = fl_mem_wb;
  assign bus.stall_pc     = st_pc;
  assign bus.stall_if_id  = st_if_id;
  assign bus.pc_redirect  = redirect;
  assign bus.pc_target    = target;
  assign bus.epc          = epc_q;
  assign bus.cause        = cause_q;
  assign bus.tval         = tval_q;
  assign bus.in_handler   = (state_q == ST_HANDLER);
  assign bus.lockup       = (state_q == ST_LOCKUP);

endmodule

// File: tb/tb_exc_pipe_ctrl.sv
// Scoreboard bench for exc_pipe_ctrl: expected output vectors are queued as each
// WB-stage stimulus is driven and compared against sampled DUT outputs per scenario.
module tb_exc_pipe_ctrl;

  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exc_pipe_ctrl_if #(.CNT_W(CNT_W)) ifc ();

  exc_pipe_ctrl #(.TRAP_VEC(32'h0000_0100), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  typedef struct packed {
    logic        rst;
    logic        inv, ld, st, mret, hz;
    logic [31:0] pc4, idata, daddr;
  } in_t;

  // flushes packed as {if_id, id_ex, ex_mem, mem_wb}
  typedef struct packed {
    logic        kill;
    logic [3:0]  fl;
    logic        spc, sif, red;
    logic [31:0] tgt, epc;
    logic [3:0]  cause;
    logic [31:0] tval;
    logic        ih, lk;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  obs_t  exp_q[$];
  obs_t  got_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic in_t stim(input logic r, inv, ld, st, mret, hz,
                               input logic [31:0] pc4, idata, daddr);
    stim = '{rst: r, inv: inv, ld: ld, st: st, mret: mret, hz: hz,
             pc4: pc4, idata: idata, daddr: daddr};
  endfunction

  function automatic obs_t ex(input logic kill, input logic [3:0] fl,
                              input logic spc, sif, red, input logic [31:0] tgt, epc,
                              input logic [3:0] cause, input logic [31:0] tval,
                              input logic ih, lk, input logic [CNT_W-1:0] cnt);
    ex = '{kill: kill, fl: fl, spc: spc, sif: sif, red: red, tgt: tgt, epc: epc,
           cause: cause, tval: tval, ih: ih, lk: lk, cnt: cnt};
  endfunction

  function automatic obs_t quiet(input logic [31:0] epc, input logic [3:0] cause,
                                 input logic [31:0] tval, input logic ih, lk,
                                 input logic [CNT_W-1:0] cnt);
    quiet = ex(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'd0, epc, cause, tval, ih, lk, cnt);
  endfunction

  // Expected counter value after n taken exceptions since reset.
  function automatic logic [CNT_W-1:0] ec(input int n);
`ifdef EXC_PIPE_CTRL_COUNT_EN
    ec = (n >= 3) ? CNT_W'(3) : CNT_W'(n);
`else
    ec = CNT_W'(n * 0);
`endif
  endfunction

  // Drive one WB-stage cycle, queue its expectation, and capture the DUT response
  // just after the inputs settle (well before the next posedge).
  task automatic drive_step(input in_t s, input obs_t e, input string nm);
    obs_t g;
    @(negedge clk);
    rst             = s.rst;
    ifc.wb_invalid  = s.inv;
    ifc.wb_mis_ld   = s.ld;
    ifc.wb_mis_st   = s.st;
    ifc.wb_mret     = s.mret;
    ifc.hz_stall    = s.hz;
    ifc.wb_pc_plus4 = s.pc4;
    ifc.wb_idata    = s.idata;
    ifc.wb_daddr    = s.daddr;
    exp_q.push_back(e);
    name_q.push_back(nm);
    #2;
    g = '{kill: ifc.wb_kill,
          fl: {ifc.flush_if_id, ifc.flush_id_ex, ifc.flush_ex_mem, ifc.flush_mem_wb},
          spc: ifc.stall_pc, sif: ifc.stall_if_id, red: ifc.pc_redirect,
          tgt: ifc.pc_target, epc: ifc.epc, cause: ifc.cause, tval: ifc.tval,
          ih: ifc.in_handler, lk: ifc.lockup, cnt: ifc.exc_count};
    got_q.push_back(g);
  endtask

  task automatic test_reset();
    obs_t e, g; string nm;
    drive_step(stim(1, 1, 1, 0, 1, 1, 32'h20, 32'hFFFF_FFFF, 32'h3), '0, "reset_held_with_event");
    drive_step(stim(0, 0, 0, 0, 0, 0, 0, 0, 0), '0, "reset_released_idle");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL %s: got %h want %h", nm, g, e); end
    end
  endtask

  task automatic test_illegal();
    obs_t e, g; string nm;
    drive_step(stim(0, 1, 0, 0, 0, 0, 32'h20, 32'hFFFF_FFFF, 32'h0),
               ex(1, 4'b1111, 0, 0, 1, 32'h100, 0, 0, 0, 0, 0, ec(0)), "illegal_trap_entry");
    drive_step(stim(0, 0, 0, 0, 0, 0, 0, 0, 0),
               quiet(32'h1C, 4'd2, 32'hFFFF_FFFF, 1, 0, ec(1)), "illegal_csrs_latched");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL %s: got %h want %h", nm, g, e); end
    end
  endtask

  task automatic test_mret_return();
    obs_t e, g; string nm;
    drive_step(stim(0, 0, 0, 0, 1, 0, 32'h999, 32'h3020_0073, 32'h0),
               ex(0, 4'b1111, 0, 0, 1, 32'h20, 32'h1C, 4'd2, 32'hFFFF_FFFF, 1, 0, ec(1)),
               "mret_redirect_epc_plus4");
    drive_step(stim(0, 0, 0, 0, 0, 0, 0, 0, 0),
               quiet(32'h1C, 4'd2, 32'hFFFF_FFFF, 0, 0, ec(1)), "mret_back_to_idle");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL %s: got %h want %h", nm, g, e); end
    end
  endtask

  task automatic test_stall();
    obs_t e, g; string nm;
    drive_step(stim(0, 0, 0, 0, 0, 1, 32'h44, 0, 0),
               ex(0, 4'b0100, 1, 1, 0, 0, 32'h1C, 4'd2, 32'hFFFF_FFFF, 0, 0, ec(1)), "idle_load_use_stall");
    drive_step(stim(0, 0, 0, 0, 0, 0, 0, 0, 0),
               quiet(32'h1C, 4'd2, 32'hFFFF_FFFF, 0, 0, ec(1)), "stall_released");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL %s: got %h want %h", nm, g, e); end
    end
  endtask

  task automatic test_misaligned();
    obs_t e, g; string nm;
    drive_step(stim(0, 0, 1, 0, 0, 1, 32'h40, 32'h1234, 32'h13),
               ex(1, 4'b1111, 0, 0, 1, 32'h100, 32'h1C, 4'd2, 32'hFFFF_FFFF, 0, 0, ec(1)),
               "mis_ld_overrides_stall");
    drive_step(stim(0, 0, 0, 0, 0, 1, 0, 0, 0),
               ex(0, 4'b0100, 1, 1, 0, 0, 32'h3C, 4'd4, 32'h13, 1, 0, ec(2)), "handler_load_use_stall");
    drive_step(stim(0, 0, 0, 0, 1, 1, 0, 0, 0),
               ex(0, 4'b1111, 0, 0, 1, 32'h40, 32'h3C, 4'd4, 32'h13, 1, 0, ec(2)), "mret_overrides_stall");
    drive_step(stim(0, 0, 0, 0, 0, 0, 0, 0, 0),
               quiet(32'h3C, 4'd4, 32'h13, 0, 0, ec(2)), "mis_ld_return_idle");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL %s: got %h want %h", nm, g, e); end
    end
  endtask

  task automatic test_lockup();
    obs_t e, g; string nm;
    drive_step(stim(0, 0, 0, 1, 0, 0, 32'h80, 32'h0, 32'h55),
               ex(1, 4'b1111, 0, 0, 1, 32'h100, 32'h3C, 4'd4, 32'h13, 0, 0, ec(2)), "mis_st_trap_entry");
    drive_step(stim(0, 0, 0, 1, 0, 0, 32'h200, 32'h0, 32'h99),
               ex(1, 4'b1111, 0, 0, 0, 0, 32'h7C, 4'd6, 32'h55, 1, 0, ec(3)), "nested_fault_kill");
    for (int i = 0; i < 10; i++) begin
      drive_step(stim(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      $urandom, $urandom, $urandom),
                 ex(0, 4'b1100, 1, 0, 0, 0, 32'h7C, 4'd6, 32'h55, 0, 1, ec(4)),
                 $sformatf("lockup_hold_%0d", i));
    end
    drive_step(stim(1, 0, 0, 0, 1, 1, 0, 0, 0), '0, "lockup_reset_clears");
    drive_step(stim(0, 0, 0, 0, 0, 0, 0, 0, 0), '0, "lockup_reset_idle");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL %s: got %h want %h", nm, g, e); end
    end
  endtask

  task automatic test_stray_mret();
    obs_t e, g; string nm;
    drive_step(stim(0, 0, 0, 0, 1, 0, 32'h0, 32'h3020_0073, 32'h7),
               ex(1, 4'b1111, 0, 0, 1, 32'h100, 0, 0, 0, 0, 0, ec(0)), "stray_mret_trap");
    drive_step(stim(0, 0, 0, 0, 1, 0, 32'h500, 0, 0),
               ex(0, 4'b1111, 0, 0, 1, 32'h0, 32'hFFFF_FFFC, 4'd2, 32'h3020_0073, 1, 0, ec(1)),
               "epc_wrap_return");
    drive_step(stim(0, 0, 0, 0, 0, 0, 0, 0, 0),
               quiet(32'hFFFF_FFFC, 4'd2, 32'h3020_0073, 0, 0, ec(1)), "wrap_back_idle");
    drive_step(stim(0, 1, 0, 0, 1, 0, 32'h84, 32'hDEAD_BEEF, 32'h1),
               ex(1, 4'b1111, 0, 0, 1, 32'h100, 32'hFFFF_FFFC, 4'd2, 32'h3020_0073, 0, 0, ec(1)),
               "invalid_with_mret_trap");
    drive_step(stim(0, 0, 0, 0, 0, 0, 0, 0, 0),
               quiet(32'h80, 4'd2, 32'hDEAD_BEEF, 1, 0, ec(2)), "invalid_with_mret_csrs");
    drive_step(stim(1, 0, 0, 0, 1, 0, 32'h84, 0, 0), '0, "reset_mid_handler");
    drive_step(stim(0, 0, 0, 0, 0, 0, 0, 0, 0), '0, "reset_mid_handler_idle");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL %s: got %h want %h", nm, g, e); end
    end
  endtask

  task automatic test_count();
    obs_t e, g; string nm;
    logic [31:0] pe, pt, pc4;
    logic [3:0]  pcause;
    pe = 0; pt = 0; pcause = 0;
    for (int k = 0; k < 4; k++) begin
      pc4 = 32'h1000 + 32'(8 * k);
      drive_step(stim(0, 1, 0, 0, 0, 0, pc4, 32'(k + 10), 0),
                 ex(1, 4'b1111, 0, 0, 1, 32'h100, pe, pcause, pt, 0, 0, ec(k)),
                 $sformatf("count_trap_%0d", k));
      drive_step(stim(0, 0, 0, 0, 1, 0, 0, 0, 0),
                 ex(0, 4'b1111, 0, 0, 1, pc4, pc4 - 32'd4, 4'd2, 32'(k + 10), 1, 0, ec(k + 1)),
                 $sformatf("count_return_%0d", k));
      pe = pc4 - 32'd4; pt = 32'(k + 10); pcause = 4'd2;
    end
    drive_step(stim(0, 0, 0, 0, 0, 0, 0, 0, 0),
               quiet(pe, 4'd2, pt, 0, 0, ec(4)), "count_saturated");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL %s: got %h want %h", nm, g, e); end
    end
  endtask

  initial begin
    ifc.wb_invalid  = 1'b0;
    ifc.wb_mis_ld   = 1'b0;
    ifc.wb_mis_st   = 1'b0;
    ifc.wb_mret     = 1'b0;
    ifc.hz_stall    = 1'b0;
    ifc.wb_pc_plus4 = 32'd0;
    ifc.wb_idata    = 32'd0;
    ifc.wb_daddr    = 32'd0;
    repeat (2) @(posedge clk);
    test_reset();
    test_illegal();
    test_mret_return();
    test_stall();
    test_misaligned();
    test_lockup();
    test_stray_mret();
    test_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
